aes_job_scheduler: RTL and testbench
====================================

// Module: aes_job_scheduler
// PURPOSE
//  Shares one AES_top encryption core among NUM_REQ independent requesters.
//  - Arbitrates round-robin and latches the winner's plaintext and key.
//  - Sequences the core with a start pulse and waits for done, with a timeout guard.
//  - Returns the ciphertext tagged with the requester id over a valid/ready response port.
//  Sits between the host-side job queues and AES_top.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..16)
//  TIMEOUT_CYC  32  max cycles waiting for core_done before abort (>= 16)
//  ID_W         $clog2(NUM_REQ)  requester id width (derived; do not override)
// PORTS
//  clk              in   1            clock, rising edge
//  rstn             in   1            asynchronous active-low reset
//  req_valid        in   NUM_REQ      per-requester job present
//  req_ready        out  NUM_REQ      one-hot accept strobe; job taken when valid&ready
//  req_plain_text   in   NUM_REQ*128  plaintext, requester i at [128*i +: 128]
//  req_cipher_key   in   NUM_REQ*128  key, requester i at [128*i +: 128]
//  core_start       out  1            one-cycle launch pulse to AES_top
//  core_plain_text  out  128          latched plaintext, stable from LAUNCH to end of WAIT
//  core_cipher_key  out  128          latched key, stable from LAUNCH to end of WAIT
//  core_done        in   1            one-cycle completion pulse from AES_top
//  core_cipher_text in   128          core result, valid when core_done=1
//  rsp_valid        out  1            response available
//  rsp_ready        in   1            consumer accepts response
//  rsp_id           out  ID_W         requester index of this response
//  rsp_cipher_text  out  128          ciphertext (0 on timeout)
//  rsp_timeout      out  1            response is an aborted job
//  busy             out  1            FSM not in IDLE
//  jobs_done        out  16           count of completed (non-timeout) jobs, wraps at 2^16
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, RR pointer 0, latched operands 0, jobs_done 0.
//  - Reset mid-operation drops any in-flight job without a response.
//    The core shares rstn and is reset in the same cycle.
//  - FSM IDLE->LAUNCH->WAIT->RESP->IDLE:
//  - IDLE: if any req_valid, grant g is the first set bit at or after ptr, wrapping.
//    - req_ready[g]=1 for that single cycle; operands and id latched.
//    - ptr<=(g+1)%NUM_REQ; next state LAUNCH.
//    - req_ready is never asserted outside IDLE.
//  - LAUNCH: core_start=1 for exactly one cycle; wait counter cleared; next state WAIT.
//  - WAIT: counter increments every cycle.
//    - core_done=1: capture core_cipher_text, rsp_timeout=0, jobs_done++, go to RESP.
//    - Otherwise, counter==TIMEOUT_CYC-1: rsp_cipher_text=0, rsp_timeout=1, go to RESP.
//    - core_done and timeout in the same cycle: done wins.
//  - core_done outside WAIT is ignored, with no state or counter effect.
//  - RESP: rsp_valid=1 with id, data and timeout held stable until rsp_ready.
//    - On rsp_valid&rsp_ready, go to IDLE.
//    - With rsp_ready tied high, RESP lasts exactly 1 cycle.
//  - Latency: accept at cycle T, core_start at T+1, earliest rsp_valid at D+1.
//    - D is the core_done cycle.
//    - Earliest next accept at the cycle after the response handshake.
//  - One job in flight at a time; requesters hold req_valid/data until req_ready.
//  - Fairness: every continuously-valid requester is granted within NUM_REQ jobs.
//  - busy=1 in LAUNCH, WAIT and RESP.
// STRUCTURE
//  - Package aes_sched_pkg:
//    - AES_BLOCK_W=128.
//    - typedef enum logic[1:0] {IDLE,LAUNCH,WAIT,RESP} sched_state_t.
//    - typedef struct {plain, key} aes_job_t.
//  - Sub-module aes_rr_arbiter:
//    - Combinational: (req, ptr) -> one-hot grant + index.
//    - Pointer register stays in the scheduler.
// TESTING
//  1 Single job: req_valid[2]=1, pt=00112233445566778899aabbccddeeff, key=000102..0f.
//    -> core_start one cycle after accept.
//    -> rsp_id=2, rsp_cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, jobs_done=1.
//  2 All 4 requesters valid continuously, rsp_ready=1, run 8 jobs.
//    -> grant order 0,1,2,3,0,1,2,3.
//    -> never two req_ready bits set; core_start count=8.
//  3 Stub core that never raises done, TIMEOUT_CYC=32.
//    -> rsp_valid 32 cycles after core_start, rsp_timeout=1, cipher 0, jobs_done unchanged.
//  4 Backpressure: rsp_ready=0 for 10 cycles after rsp_valid.
//    -> rsp fields stable, no req_ready, no core_start until handshake.
//  5 rstn low in WAIT -> all outputs 0 next eval, no response.
//    -> after release, a new job completes normally.
//  6 Spurious core_done in IDLE/RESP, plus done coincident with the timeout cycle.
//    -> first ignored; second yields rsp_timeout=0 with the core data.

Source files
------------

// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_sched_pkg
// Description : Shared types and constants for the AES job scheduler.
//               AES_BLOCK_W   - width of one AES block / key
//               sched_state_t - scheduler FSM states
//               aes_job_t     - latched plaintext + key of one job
// Revision    : 1.0 - initial release
// ============================================================================
package aes_sched_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [AES_BLOCK_W-1:0] plain;
        logic [AES_BLOCK_W-1:0] key;
    } aes_job_t;

endpackage
`default_nettype wire

// File: rtl/aes_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_rr_arbiter
// Description : Purely combinational round-robin arbiter. Picks the first
//               asserted request at or after the pointer, wrapping around.
//               The pointer register lives in the caller.
// Ports       : i_req         - request vector
//               i_ptr         - index with highest priority this cycle
//               o_grant       - one-hot grant (zero when no request)
//               o_grant_idx   - index of the granted request
//               o_grant_valid - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module aes_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_grant_valid
);

    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down to the pointer itself so the last
    // hit written, i.e. the closest one at/after the pointer, wins.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = ID_W'((int'(i_ptr) + off) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
                o_grant_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : aes_job_scheduler
// Description : Shares one AES_top core among NUM_REQ requesters. Grants
//               round-robin, latches the winner's operands, pulses
//               core_start, waits for core_done (with a timeout guard) and
//               returns the ciphertext tagged with the requester id.
// Ports       : clk, rstn                 - clock / async active-low reset
//               req_valid/req_ready       - per-requester job handshake
//               req_plain_text/cipher_key - packed operands, req i at [128*i +: 128]
//               core_start/plain/key      - launch interface to AES_top
//               core_done/core_cipher_text- completion from AES_top
//               rsp_valid/ready/id/...    - tagged response port
//               busy                      - FSM not idle
//               jobs_done                 - completed (non-timeout) job count
// Revision    : 1.0 - initial release
// ============================================================================
module aes_job_scheduler
    import aes_sched_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int TIMEOUT_CYC = 32,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_plain_text,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_cipher_key,
    output logic                         core_start,
    output logic [AES_BLOCK_W-1:0]       core_plain_text,
    output logic [AES_BLOCK_W-1:0]       core_cipher_key,
    input  logic                         core_done,
    input  logic [AES_BLOCK_W-1:0]       core_cipher_text,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [AES_BLOCK_W-1:0]       rsp_cipher_text,
    output logic                         rsp_timeout,
    output logic                         busy,
    output logic [15:0]                  jobs_done
);

    localparam int              CNT_W      = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    sched_state_t           r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_id;
    aes_job_t               r_job;
    logic [CNT_W-1:0]       r_wait_cnt;
    logic                   r_core_start;
    logic                   r_rsp_valid;
    logic                   r_rsp_timeout;
    logic [AES_BLOCK_W-1:0] r_rsp_ct;
    logic [15:0]            r_jobs_done;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_grant_valid;
    logic                   w_accept;

    logic [AES_BLOCK_W-1:0] w_pt_arr  [NUM_REQ];
    logic [AES_BLOCK_W-1:0] w_key_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_pt_arr[g]  = req_plain_text[AES_BLOCK_W*g +: AES_BLOCK_W];
        assign w_key_arr[g] = req_cipher_key[AES_BLOCK_W*g +: AES_BLOCK_W];
    end

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req         (req_valid),
        .i_ptr         (r_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign w_accept = (r_state == IDLE) && w_grant_valid;

    // The accept strobe is a decode of the IDLE state; gating with rstn keeps
    // it low while reset is held even if requesters are already valid.
    assign req_ready       = (rstn && r_state == IDLE) ? w_grant : '0;
    assign core_start      = r_core_start;
    assign core_plain_text = r_job.plain;
    assign core_cipher_key = r_job.key;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_id          = r_id;
    assign rsp_cipher_text = r_rsp_ct;
    assign rsp_timeout     = r_rsp_timeout;
    assign busy            = (r_state != IDLE);
    assign jobs_done       = r_jobs_done;

    // The wait counter is zeroed on accept and counts the LAUNCH cycle too,
    // so it equals the number of cycles since core_start. The timeout then
    // fires TIMEOUT_CYC-1 cycles after launch and rsp_valid rises exactly
    // TIMEOUT_CYC cycles after core_start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_id          <= '0;
            r_job         <= '0;
            r_wait_cnt    <= '0;
            r_core_start  <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_ct      <= '0;
            r_jobs_done   <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_job.plain  <= w_pt_arr[w_grant_idx];
                        r_job.key    <= w_key_arr[w_grant_idx];
                        r_id         <= w_grant_idx;
                        r_ptr        <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ?
                                        '0 : w_grant_idx + 1'b1;
                        r_wait_cnt   <= '0;
                        r_core_start <= 1'b1;
                        r_state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    // core_done is checked first so a completion arriving on
                    // the timeout cycle still returns real data.
                    if (core_done) begin
                        r_rsp_ct      <= core_cipher_text;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_jobs_done   <= r_jobs_done + 16'd1;
                        r_state       <= RESP;
                    end else if (r_wait_cnt == C_CNT_LAST) begin
                        r_rsp_ct      <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aes_job_scheduler
// Description : Self-checking bench for aes_job_scheduler. Requester driver,
//               stub AES core, scoreboard monitor and directed test sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_job_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 32;
    localparam int ID_W        = 2;

    localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*128-1:0]   req_plain_text;
    logic [NUM_REQ*128-1:0]   req_cipher_key;
    logic                     core_start;
    logic [127:0]             core_plain_text;
    logic [127:0]             core_cipher_key;
    logic                     core_done;
    logic [127:0]             core_cipher_text;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [127:0]             rsp_cipher_text;
    logic                     rsp_timeout;
    logic                     busy;
    logic [15:0]              jobs_done;

    aes_job_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_plain_text   (req_plain_text),
        .req_cipher_key   (req_cipher_key),
        .core_start       (core_start),
        .core_plain_text  (core_plain_text),
        .core_cipher_key  (core_cipher_key),
        .core_done        (core_done),
        .core_cipher_text (core_cipher_text),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_cipher_text  (rsp_cipher_text),
        .rsp_timeout      (rsp_timeout),
        .busy             (busy),
        .jobs_done        (jobs_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [127:0] ct;
        bit           to;
    } exp_t;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    logic [127:0] pt_r  [NUM_REQ];
    logic [127:0] key_r [NUM_REQ];
    int           pend  [NUM_REQ];
    int           stub_lat = 4;
    bit           spur = 1'b0;
    int           stub_cnt;
    logic [127:0] stub_ct;
    int           accept_cyc = 0;
    int           start_cyc = 0;
    int           done_cyc = 0;
    int           n_start = 0;
    int           n_rsp = 0;
    int           viol = 0;
    int           exp_jobs = 0;
    int           grant_log [$];
    exp_t         exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for AES_top: the real FIPS-197 vector maps to its known
    // ciphertext, anything else gets an arbitrary but fixed mixing.
    function automatic logic [127:0] model(input logic [127:0] p, input logic [127:0] k);
        if (p == VEC_PT && k == VEC_KEY) return VEC_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Requester driver: records accepts, pushes expected responses.
    initial begin : drv
        logic [NUM_REQ-1:0] acc;
        exp_t de;
        req_valid      = '0;
        req_plain_text = '0;
        req_cipher_key = '0;
        forever begin
            @(negedge clk);
            acc = req_valid & req_ready;
            if ($countones(req_ready) > 1 || (busy && req_ready != '0)) viol++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    de.id = i;
                    de.to = (stub_lat < 0);
                    de.ct = de.to ? 128'h0 : model(pt_r[i], key_r[i]);
                    exp_q.push_back(de);
                    grant_log.push_back(i);
                    accept_cyc = cyc;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) begin
                    pend[i]  = pend[i] - 1;
                    pt_r[i]  = pt_r[i] + 128'd1;
                    key_r[i] = key_r[i] + 128'd3;
                end
                req_valid[i] = rstn && (pend[i] > 0);
                req_plain_text[128*i +: 128] = pt_r[i];
                req_cipher_key[128*i +: 128] = key_r[i];
            end
        end
    end

    // Stub core: done stub_lat cycles after core_start (never if negative).
    initial begin : stub
        core_done        = 1'b0;
        core_cipher_text = '0;
        stub_cnt         = -1;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (!rstn) begin
                stub_cnt = -1;
            end else if (core_start) begin
                start_cyc = cyc;
                n_start++;
                stub_ct  = model(core_plain_text, core_cipher_key);
                stub_cnt = stub_lat;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    core_done        = 1'b1;
                    core_cipher_text = stub_ct;
                    done_cyc         = cyc;
                    stub_cnt         = -1;
                end
            end
            if (spur && !core_done) begin
                core_done        = 1'b1;
                core_cipher_text = '1;
                spur             = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : mon
        exp_t me;
        forever begin
            @(negedge clk);
            if (rstn && rsp_valid && rsp_ready) begin
                n_rsp++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id %0d, expected no response", rsp_id);
                end else begin
                    me = exp_q.pop_front();
                    check("rsp_id", 128'(rsp_id), 128'(me.id));
                    check("rsp_cipher_text", rsp_cipher_text, me.ct);
                    check("rsp_timeout", 128'(rsp_timeout), 128'(me.to));
                    if (!me.to) exp_jobs++;
                    check("jobs_done", 128'(jobs_done), 128'(exp_jobs));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 128'({req_ready, core_start, rsp_valid, rsp_id,
                                    rsp_timeout, busy, jobs_done}), 128'h0);
        check({tag, "_core_pt"}, core_plain_text, 128'h0);
        check({tag, "_core_key"}, core_cipher_key, 128'h0);
        check({tag, "_rsp_ct"}, rsp_cipher_text, 128'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
        exp_q.delete();
        grant_log.delete();
        exp_jobs = 0;
        @(negedge clk);
        check_reset_outputs(tag);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input int budget, output int c);
        int k = 0;
        @(negedge clk);
        while (!rsp_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        c = cyc;
        check({tag, "_rsp_seen"}, 128'(rsp_valid), 128'h1);
    endtask

    task automatic wait_rsp_count(input string tag, input int target, input int budget);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rsp_count"}, 128'(n_rsp), 128'(target));
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", 128'({busy, rsp_valid}), 128'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : seq
        int c;
        int r0;
        int s0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i]  = 0;
            pt_r[i]  = '0;
            key_r[i] = '0;
        end
        do_reset("reset");

        // 1: single job with the FIPS-197 vector on requester 2
        pt_r[2]  = VEC_PT;
        key_r[2] = VEC_KEY;
        stub_lat = 5;
        pend[2]  = 1;
        wait_rsp("t1", 40, c);
        check("t1_start_latency", 128'(start_cyc - accept_cyc), 128'd1);
        check("t1_rsp_latency", 128'(c - done_cyc), 128'd1);
        wait_idle(10);

        // 2: all requesters continuously valid, 8 jobs
        do_reset("t2_reset");
        for (int i = 0; i < NUM_REQ; i++) begin
            pt_r[i]  = {32'(i), 96'h1111_2222_3333_4444_5555_6666};
            key_r[i] = {96'hcafe_f00d_dead_beef_0bad_c0de, 32'(i)};
            pend[i]  = 2;
        end
        stub_lat = 2;
        r0 = n_rsp;
        s0 = n_start;
        wait_rsp_count("t2", r0 + 8, 300);
        check("t2_grant_count", 128'(grant_log.size()), 128'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            check("t2_grant_order", 128'(grant_log[k]), 128'(k % 4));
        check("t2_core_start_count", 128'(n_start - s0), 128'd8);
        wait_idle(10);

        // 3: core never completes -> timeout
        stub_lat = -1;
        pend[1]  = 1;
        wait_rsp("t3", 60, c);
        check("t3_timeout_latency", 128'(c - start_cyc), 128'(TIMEOUT_CYC));
        wait_idle(10);

        // 4: response backpressure for 10 cycles
        stub_lat  = 3;
        rsp_ready = 1'b0;
        pend[0]   = 1;
        pend[3]   = 1;
        r0 = n_rsp;
        wait_rsp("t4", 40, c);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t4_hold_ctrl",
                  128'({rsp_valid, rsp_timeout, rsp_id, core_start, req_ready}),
                  128'({1'b1, exp_q[0].to, ID_W'(exp_q[0].id), 1'b0, 4'b0}));
            check("t4_hold_ct", rsp_cipher_text, exp_q[0].ct);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp_count("t4", r0 + 2, 60);
        wait_idle(10);

        // 5: reset while waiting on the core, then a normal job
        stub_lat = -1;
        pend[2]  = 1;
        tick(8);
        check("t5_busy_before_reset", 128'(busy), 128'h1);
        do_reset("t5_reset");
        check("t5_no_rsp", 128'(rsp_valid), 128'h0);
        stub_lat = 4;
        pend[0]  = 1;
        wait_rsp("t5", 40, c);
        wait_idle(10);

        // 6a: spurious done while idle
        @(posedge clk);
        #1;
        spur = 1'b1;
        tick(4);
        @(negedge clk);
        check("t6_idle_state", 128'({busy, rsp_valid}), 128'h0);
        check("t6_idle_jobs", 128'(jobs_done), 128'(exp_jobs));

        // 6b: spurious done while a response is held
        rsp_ready = 1'b0;
        stub_lat  = 2;
        pend[1]   = 1;
        wait_rsp("t6b", 30, c);
        @(posedge clk);
        #1;
        spur = 1'b1;
        tick(3);
        @(negedge clk);
        check("t6_resp_ct", rsp_cipher_text, exp_q[0].ct);
        check("t6_resp_jobs", 128'(jobs_done), 128'(exp_jobs + 1));
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle(10);

        // 6c: done on the same cycle the timeout would fire
        stub_lat = TIMEOUT_CYC - 1;
        pend[3]  = 1;
        wait_rsp("t6c", 60, c);
        check("t6_coincident_latency", 128'(c - start_cyc), 128'(TIMEOUT_CYC));
        wait_idle(10);

        check("req_ready_onehot_idle_only", 128'(viol), 128'h0);
        check("scoreboard_empty", 128'(exp_q.size()), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
